// File: rtl/wdt_ctrl_pkg.sv
// Shared definitions for the watchdog control front-end: register offsets,
// default kick key, STATUS bit positions, kick FSM states and a saturating counter helper.
package wdt_ctrl_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_KICK   = 2'd1;
  localparam logic [1:0] ADDR_TOCNT  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam logic [31:0] KICK_KEY_DEF = 32'h5A5A_A5A5;

  localparam int STATUS_TO_BIT   = 0;
  localparam int STATUS_BUSY_BIT = 1;
  localparam int STATUS_CNT_LSB  = 8;
  localparam int STATUS_CNT_MSB  = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } kick_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/wdt_ctrl_sync_edge.sv
// Two-flop synchroniser for an asynchronous level, followed by a rising-edge
// detector producing a one-cycle pulse in the clk domain.
module wdt_ctrl_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic pulse
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // synchroniser chain plus delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      prev_r <= 1'b0;
    end else begin
      meta_r <= async_in;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign pulse = sync_r & ~prev_r;

endmodule

// File: rtl/wdt_ctrl.sv
// Bus register front-end for the watchdog timer: CTRL/KICK/TOCNT/STATUS, kick
// pulse stretcher and WTO capture. Optional macro WDT_CTRL_AUTODIS_EN: WTO edge clears WDEN.
module wdt_ctrl
  import wdt_ctrl_pkg::*;
#(
  parameter int          LIVE_HOLD = 8,
  parameter int          LIVE_GAP  = 4,
  parameter logic [31:0] KICK_KEY  = KICK_KEY_DEF,
  parameter logic [31:0] TOCNT_RST = 32'h0000_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  input  logic        WTO,
  output logic        WDEN,
  output logic        WDLIVE,
  output logic [31:0] WTOCNT,
  output logic        wto_irq
);

  localparam logic [7:0] HOLD_RELOAD = 8'(LIVE_HOLD - 1);
  localparam logic [7:0] GAP_RELOAD  = 8'(LIVE_GAP - 1);

  kick_state_t state_r, state_s;
  logic [7:0]  cnt_r, cnt_s;
  logic        pending_r, pending_s;
  logic        wdlive_r;
  logic        wden_r, wden_s;
  logic [31:0] tocnt_r, tocnt_s;
  logic        to_r, to_s;
  logic [7:0]  to_cnt_r, to_cnt_s;
  logic        ack_r;
  logic [31:0] rdata_r, rdata_s;
  logic [31:0] rd_mux_s;
  logic [1:0]  addr_s;
  logic        wr_s, rd_s, kick_s, w1c_s, ctrl_wr_s, tocnt_wr_s;
  logic        wto_edge_s;
  logic        unused_addr_s;

  assign unused_addr_s = ^bus_addr[1:0];

  wdt_ctrl_sync_edge u_sync_edge (
    .clk      (clk),
    .rst      (rst),
    .async_in (WTO),
    .pulse    (wto_edge_s)
  );

  // bus access decode
  always_comb begin
    addr_s     = bus_addr[3:2];
    wr_s       = bus_req & bus_we;
    rd_s       = bus_req & ~bus_we;
    ctrl_wr_s  = wr_s && (addr_s == ADDR_CTRL);
    tocnt_wr_s = wr_s && (addr_s == ADDR_TOCNT);
    kick_s     = wr_s && (addr_s == ADDR_KICK) && (bus_wdata == KICK_KEY);
    w1c_s      = wr_s && (addr_s == ADDR_STATUS) && bus_wdata[STATUS_TO_BIT];
  end

  // read mux on current register state
  always_comb begin
    rd_mux_s = 32'd0;
    case (addr_s)
      ADDR_CTRL:   rd_mux_s = {31'd0, wden_r};
      ADDR_KICK:   rd_mux_s = 32'd0;
      ADDR_TOCNT:  rd_mux_s = tocnt_r;
      ADDR_STATUS: begin
        rd_mux_s[STATUS_TO_BIT]                  = to_r;
        rd_mux_s[STATUS_BUSY_BIT]                = (state_r != IDLE);
        rd_mux_s[STATUS_CNT_MSB:STATUS_CNT_LSB]  = to_cnt_r;
      end
      default:     rd_mux_s = 32'd0;
    endcase
    if (rd_s) begin
      rdata_s = rd_mux_s;
    end else begin
      rdata_s = 32'd0;
    end
  end

  // register next-state: enable, locked reload count, sticky timeout status
  always_comb begin
    wden_s   = wden_r;
    tocnt_s  = tocnt_r;
    to_s     = to_r;
    to_cnt_s = to_cnt_r;
`ifdef WDT_CTRL_AUTODIS_EN
    if (wto_edge_s) begin
      wden_s = 1'b0;
    end else if (ctrl_wr_s) begin
      wden_s = bus_wdata[0];
    end else begin
      wden_s = wden_r;
    end
`else
    if (ctrl_wr_s) begin
      wden_s = bus_wdata[0];
    end else begin
      wden_s = wden_r;
    end
`endif
    if (tocnt_wr_s && !wden_r) begin
      tocnt_s = bus_wdata;
    end else begin
      tocnt_s = tocnt_r;
    end
    // a fresh timeout outranks a simultaneous software clear
    if (wto_edge_s) begin
      to_s     = 1'b1;
      to_cnt_s = w1c_s ? 8'd1 : sat_inc8(to_cnt_r);
    end else if (w1c_s) begin
      to_s     = 1'b0;
      to_cnt_s = 8'd0;
    end else begin
      to_s     = to_r;
      to_cnt_s = to_cnt_r;
    end
  end

  // kick stretcher FSM: HOLD drives WDLIVE, GAP guarantees a low interval
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    pending_s = pending_r;
    case (state_r)
      IDLE: begin
        if (kick_s) begin
          state_s = HOLD;
          cnt_s   = HOLD_RELOAD;
        end else begin
          state_s = IDLE;
        end
      end
      HOLD: begin
        if (kick_s) begin
          cnt_s = HOLD_RELOAD;
        end else if (cnt_r == 8'd0) begin
          state_s = GAP;
          cnt_s   = GAP_RELOAD;
        end else begin
          cnt_s = cnt_r - 8'd1;
        end
      end
      GAP: begin
        if (cnt_r == 8'd0) begin
          pending_s = 1'b0;
          if (pending_r || kick_s) begin
            state_s = HOLD;
            cnt_s   = HOLD_RELOAD;
          end else begin
            state_s = IDLE;
          end
        end else begin
          cnt_s     = cnt_r - 8'd1;
          pending_s = pending_r | kick_s;
        end
      end
      default: begin
        state_s   = IDLE;
        cnt_s     = 8'd0;
        pending_s = 1'b0;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= 8'd0;
      pending_r <= 1'b0;
      wdlive_r  <= 1'b0;
      wden_r    <= 1'b0;
      tocnt_r   <= TOCNT_RST;
      to_r      <= 1'b0;
      to_cnt_r  <= 8'd0;
      ack_r     <= 1'b0;
      rdata_r   <= 32'd0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      pending_r <= pending_s;
      wdlive_r  <= (state_s == HOLD);
      wden_r    <= wden_s;
      tocnt_r   <= tocnt_s;
      to_r      <= to_s;
      to_cnt_r  <= to_cnt_s;
      ack_r     <= bus_req;
      rdata_r   <= rdata_s;
    end
  end

  assign bus_ack   = ack_r;
  assign bus_rdata = rdata_r;
  assign WDEN      = wden_r;
  assign WDLIVE    = wdlive_r;
  assign WTOCNT    = tocnt_r;
  assign wto_irq   = to_r;

endmodule

// File: tb/tb_wdt_ctrl.sv
// Self-checking bench for wdt_ctrl: expected read data is queued at request
// time and compared when the acknowledged response appears.
module tb_wdt_ctrl;

  localparam logic [3:0]  A_CTRL   = 4'h0;
  localparam logic [3:0]  A_KICK   = 4'h4;
  localparam logic [3:0]  A_TOCNT  = 4'h8;
  localparam logic [3:0]  A_STATUS = 4'hC;
  localparam logic [31:0] KEY      = 32'h5A5A_A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_req = 1'b0;
  logic        bus_we = 1'b0;
  logic [3:0]  bus_addr = 4'h0;
  logic [31:0] bus_wdata = 32'd0;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        WTO = 1'b0;
  logic        WDEN;
  logic        WDLIVE;
  logic [31:0] WTOCNT;
  logic        wto_irq;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  string       nm_q[$];

  wdt_ctrl dut (
    .clk(clk), .rst(rst), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .WTO(WTO), .WDEN(WDEN), .WDLIVE(WDLIVE),
    .WTOCNT(WTOCNT), .wto_irq(wto_irq)
  );

  initial forever #5 clk = ~clk;

  // called at a negedge; returns at the next negedge with the response checked
  task automatic bus_read(input logic [3:0] addr, input logic [31:0] exp, input string nm);
    logic [31:0] e;
    string n;
    exp_q.push_back(exp);
    nm_q.push_back(nm);
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = addr; bus_wdata = 32'd0;
    @(negedge clk);
    bus_req = 1'b0;
    e = exp_q.pop_front();
    n = nm_q.pop_front();
    checks++;
    if (bus_ack !== 1'b1) begin
      failures++;
      $display("FAIL %s_ack got=%b want=1", n, bus_ack);
    end
    checks++;
    if (bus_rdata !== e) begin
      failures++;
      $display("FAIL %s got=%h want=%h", n, bus_rdata, e);
    end
  endtask

  task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = addr; bus_wdata = data;
    @(negedge clk);
    bus_req = 1'b0; bus_we = 1'b0;
    checks++;
    if (bus_ack !== 1'b1) begin
      failures++;
      $display("FAIL write_ack addr=%h got=%b want=1", addr, bus_ack);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (WDEN !== 1'b0)       begin failures++; $display("FAIL rst_wden got=%b want=0", WDEN); end
    checks++; if (WDLIVE !== 1'b0)     begin failures++; $display("FAIL rst_wdlive got=%b want=0", WDLIVE); end
    checks++; if (WTOCNT !== 32'h0000_FFFF) begin failures++; $display("FAIL rst_wtocnt got=%h want=0000ffff", WTOCNT); end
    checks++; if (bus_ack !== 1'b0)    begin failures++; $display("FAIL rst_ack got=%b want=0", bus_ack); end
    checks++; if (bus_rdata !== 32'd0) begin failures++; $display("FAIL rst_rdata got=%h want=0", bus_rdata); end
    checks++; if (wto_irq !== 1'b0)    begin failures++; $display("FAIL rst_irq got=%b want=0", wto_irq); end
    rst = 1'b0;
    @(negedge clk);
    bus_read(A_CTRL,   32'd0,          "rst_ctrl");
    bus_read(A_KICK,   32'd0,          "rst_kick");
    bus_read(A_TOCNT,  32'h0000_FFFF,  "rst_tocnt");
    bus_read(A_STATUS, 32'd0,          "rst_status");
    @(negedge clk);
    checks++; if (bus_ack !== 1'b0) begin failures++; $display("FAIL ack_idle got=%b want=0", bus_ack); end
  endtask

  task automatic test_tocnt_lock();
    bus_write(A_TOCNT, 32'd100);
    bus_write(A_CTRL, 32'd1);
    bus_write(A_TOCNT, 32'd5);
    bus_read(A_TOCNT, 32'd100, "tocnt_locked");
    bus_read(A_CTRL, 32'd1, "ctrl_en");
    checks++; if (WDEN !== 1'b1) begin failures++; $display("FAIL wden_port got=%b want=1", WDEN); end
    bus_write(A_CTRL, 32'd0);
    bus_write(A_TOCNT, 32'd5);
    bus_read(A_TOCNT, 32'd5, "tocnt_unlocked");
    checks++; if (WTOCNT !== 32'd5) begin failures++; $display("FAIL wtocnt_port got=%h want=5", WTOCNT); end
  endtask

  task automatic test_kick();
    int hi;
    bit seen;
    bus_write(A_KICK, KEY);
    hi = 0;
    while (WDLIVE === 1'b1 && hi < 64) begin hi++; @(negedge clk); end
    checks++; if (hi != 8) begin failures++; $display("FAIL kick_pulse_len got=%0d want=8", hi); end
    repeat (3) @(negedge clk);
    bus_read(A_STATUS, 32'h0000_0002, "busy_last_gap");
    bus_read(A_STATUS, 32'h0000_0000, "busy_idle");
    bus_write(A_KICK, 32'h0000_1234);
    seen = 1'b0;
    repeat (12) begin if (WDLIVE !== 1'b0) seen = 1'b1; @(negedge clk); end
    checks++; if (seen) begin failures++; $display("FAIL bad_key_pulse got=1 want=0"); end
    bus_read(A_STATUS, 32'd0, "bad_key_status");
  endtask

  task automatic test_back_to_back();
    int hi;
    int lo;
    bus_write(A_KICK, KEY);
    hi = 0;
    for (int i = 0; i < 4; i++) begin if (WDLIVE === 1'b1) hi++; @(negedge clk); end
    if (WDLIVE === 1'b1) hi++;
    bus_write(A_KICK, KEY);
    while (WDLIVE === 1'b1 && hi < 64) begin hi++; @(negedge clk); end
    checks++; if (hi != 13) begin failures++; $display("FAIL extend_len got=%0d want=13", hi); end
    lo = 0;
    if (WDLIVE === 1'b0) lo++;
    @(negedge clk);
    if (WDLIVE === 1'b0) lo++;
    bus_write(A_KICK, KEY);
    while (WDLIVE === 1'b0 && lo < 64) begin lo++; @(negedge clk); end
    checks++; if (lo != 4) begin failures++; $display("FAIL gap_len got=%0d want=4", lo); end
    hi = 0;
    while (WDLIVE === 1'b1 && hi < 64) begin hi++; @(negedge clk); end
    checks++; if (hi != 8) begin failures++; $display("FAIL pending_len got=%0d want=8", hi); end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_wto();
    for (int i = 0; i < 3; i++) begin
      WTO = 1'b1; repeat (4) @(negedge clk);
      WTO = 1'b0; repeat (4) @(negedge clk);
    end
    bus_read(A_STATUS, 32'h0000_0301, "wto_three");
    checks++; if (wto_irq !== 1'b1) begin failures++; $display("FAIL irq_set got=%b want=1", wto_irq); end
    WTO = 1'b1;
    repeat (2) @(negedge clk);
    bus_write(A_STATUS, 32'd1);
    bus_read(A_STATUS, 32'h0000_0101, "w1c_vs_edge");
    WTO = 1'b0;
    repeat (4) @(negedge clk);
    bus_write(A_STATUS, 32'd1);
    bus_read(A_STATUS, 32'd0, "w1c_clear");
    checks++; if (wto_irq !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b want=0", wto_irq); end
  endtask

  task automatic test_autodis();
    logic prev;
    int n;
    bus_write(A_CTRL, 32'd1);
    WTO = 1'b1;
    prev = WDEN;
    n = 0;
    while (wto_irq !== 1'b1 && n < 20) begin prev = WDEN; @(negedge clk); n++; end
    checks++; if (wto_irq !== 1'b1) begin failures++; $display("FAIL autodis_irq got=%b want=1", wto_irq); end
`ifdef WDT_CTRL_AUTODIS_EN
    checks++; if (prev !== 1'b1 || WDEN !== 1'b0) begin failures++; $display("FAIL autodis_wden before=%b after=%b want=1/0", prev, WDEN); end
`else
    checks++; if (prev !== 1'b1 || WDEN !== 1'b1) begin failures++; $display("FAIL keep_wden before=%b after=%b want=1/1", prev, WDEN); end
`endif
    WTO = 1'b0;
    repeat (4) @(negedge clk);
    bus_write(A_CTRL, 32'd0);
    bus_write(A_STATUS, 32'd1);
  endtask

  task automatic test_reset_mid();
    WTO = 1'b1; repeat (4) @(negedge clk);
    WTO = 1'b0; repeat (4) @(negedge clk);
    bus_write(A_TOCNT, 32'd7);
    bus_write(A_KICK, KEY);
    @(negedge clk);
    checks++; if (WDLIVE !== 1'b1) begin failures++; $display("FAIL pre_rst_live got=%b want=1", WDLIVE); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (WDLIVE !== 1'b0)  begin failures++; $display("FAIL mid_rst_live got=%b want=0", WDLIVE); end
    checks++; if (WTOCNT !== 32'h0000_FFFF) begin failures++; $display("FAIL mid_rst_wtocnt got=%h want=0000ffff", WTOCNT); end
    checks++; if (wto_irq !== 1'b0) begin failures++; $display("FAIL mid_rst_irq got=%b want=0", wto_irq); end
    bus_read(A_STATUS, 32'd0, "mid_rst_status");
    repeat (10) @(negedge clk);
    checks++; if (WDLIVE !== 1'b0)  begin failures++; $display("FAIL post_rst_live got=%b want=0", WDLIVE); end
  endtask

  initial begin
    test_reset();
    test_tocnt_lock();
    test_kick();
    test_back_to_back();
    test_wto();
    test_autodis();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wdt_ctrl.md
Name: wdt_ctrl

Overview:
- Bus-side register front-end that drives the watchdog timer's control interface (WDEN, WDLIVE, WTOCNT) and consumes its timeout output (WTO).
- Sits in the system-clock domain between the CPU bus and the watchdog timer.
- Stretches each software kick into a WDLIVE pulse long enough for the slow WDT clock to sample.
- Synchronises WTO back into this domain and records timeouts in a sticky status with an interrupt.

Parameters:
- LIVE_HOLD, 8: system-clock cycles WDLIVE stays high per kick (>=1).
- LIVE_GAP, 4: minimum low cycles between two WDLIVE pulses (>=1).
- KICK_KEY, 32'h5A5A_A5A5: value that must be written to KICK to issue a kick.
- TOCNT_RST, 32'h0000_FFFF: reset value of WTOCNT.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- bus_req  in  1  access strobe, one access per cycle.
- bus_we  in  1  1 = write, 0 = read.
- bus_addr  in  4  byte address; only [3:2] decoded.
- bus_wdata  in  32  write data.
- bus_rdata  out  32  read data, valid with bus_ack.
- bus_ack  out  1  registered bus_req (1-cycle latency).
- WTO  in  1  timeout from WDT; asynchronous to clk.
- WDEN  out  1  watchdog enable.
- WDLIVE  out  1  stretched kick pulse.
- WTOCNT  out  32  timeout reload count.
- wto_irq  out  1  level interrupt = STATUS.TO.

Behaviour:
- Reset values: WDEN=0, WDLIVE=0, WTOCNT=TOCNT_RST, bus_ack=0, bus_rdata=0, wto_irq=0, STATUS=0, kick FSM in IDLE, pending=0.
- Register map, decoded on addr[3:2]:
  - 0x0 CTRL: [0] WDEN, R/W.
  - 0x4 KICK: write-only; reads return 0.
  - 0x8 TOCNT: R/W.
  - 0xC STATUS: [0] TO sticky, W1C; [1] LIVE_BUSY, RO (FSM != IDLE); [15:8] TO_CNT, 8-bit saturating at 255, cleared when [0] is written 1; other bits read 0.
- Bus timing: a write takes effect on the cycle after bus_req; bus_ack and bus_rdata follow one cycle after bus_req. Reads return register state sampled at the request cycle.
- TOCNT lock: writes to TOCNT while WDEN=1 are ignored, still acked. A CTRL write clearing WDEN unlocks TOCNT from the next cycle.
- Kick FSM, states IDLE, HOLD, GAP; 8-bit down-counter cnt:
  - A kick is a KICK write with wdata == KICK_KEY. Non-matching writes are ignored.
  - IDLE + kick -> HOLD, cnt = LIVE_HOLD-1, WDLIVE=1.
  - HOLD: WDLIVE=1. A kick reloads cnt = LIVE_HOLD-1 (extends the pulse). When cnt==0 -> GAP, cnt = LIVE_GAP-1.
  - GAP: WDLIVE=0. A kick sets pending. When cnt==0: pending ? (HOLD, clear pending) : IDLE.
  - WDLIVE is driven registered from the state (HOLD => 1), glitch-free.
  - Kicks are honoured regardless of WDEN.
- WTO path:
  - 2-flop synchroniser, then rising-edge detect on the synchronised signal.
  - An edge sets STATUS.TO and increments TO_CNT (saturating).
  - Edge and W1C in the same cycle: set wins; TO_CNT becomes 1.
- Reset mid-operation: rst in any state returns all state to reset values on the next edge, including mid-HOLD. WDLIVE drops in the same edge.

Optional Feature:
- Macro WDT_CTRL_AUTODIS_EN.
- Defined: a WTO rising edge also clears WDEN in the same cycle STATUS.TO sets. Software must rewrite CTRL to re-arm. A CTRL write in that same cycle loses to the auto-clear.
- Undefined: WDEN is changed only by CTRL writes and reset.

Decomposition:
- Package wdt_ctrl_pkg holds:
  - register offsets (ADDR_CTRL=2'd0, ADDR_KICK=2'd1, ADDR_TOCNT=2'd2, ADDR_STATUS=2'd3);
  - the default KICK_KEY;
  - STATUS bit positions;
  - typedef enum logic [1:0] kick_state_t {IDLE, HOLD, GAP}.
- One sub-module, wdt_ctrl_sync_edge: 2-flop synchroniser plus rising-edge pulse output, with sync reset.

Test Plan:
- Reset, read all four registers -> CTRL=0, KICK=0, TOCNT=32'h0000_FFFF, STATUS=0; bus_ack exactly one cycle after each bus_req.
- Write TOCNT=100, write CTRL=1, write TOCNT=5, read TOCNT -> 100. Then write CTRL=0, write TOCNT=5 -> reads 5.
- Kick with the key -> WDLIVE high exactly 8 cycles, LIVE_BUSY=1 through HOLD+GAP (12 cycles). Kick with 32'h1234 -> no pulse.
- Kick, second kick 5 cycles later (in HOLD) -> single 13-cycle pulse. Kick during GAP -> second 8-cycle pulse starting exactly 4 low cycles after the first ends.
- Toggle WTO 0->1->0 three times -> STATUS=0x0301, wto_irq=1. Write STATUS=1 coincident with a synchronised WTO edge -> STATUS=0x0101. Write 1 with no edge -> 0, irq=0.
- Assert rst mid-HOLD -> WDLIVE=0 next cycle, STATUS=0, WTOCNT=TOCNT_RST. With WDT_CTRL_AUTODIS_EN defined, a WTO edge while WDEN=1 -> WDEN=0 in the same cycle STATUS.TO sets.
